clkdiv_prog: RTL and testbench
==============================

Name: clkdiv_prog

Overview:
Parametrised, fully synchronous clock-enable generator; next generation of the ripple-flop divider.
- Produces NUM_CH independent single-cycle tick strobes from one clock.
- Each channel has a runtime-programmable integer divide ratio instead of fixed power-of-two taps.
- Sits at the top of the synth datapath. Default channel 0/1/2 ratios of 1/4/8 give the modulator, sample and ADSR rates.
- Consumers use ticks as clock enables on clk, so no derived clocks exist.

Parameters:
- NUM_CH, 3, number of divider channels (1..8).
- DIV_W, 8, width of each divide-ratio register and counter.
- DIV_INIT, {8'd8, 8'd4, 8'd1}, NUM_CH*DIV_W reset ratios. Channel i uses slice [i*DIV_W +: DIV_W].

Ports:
- clk  in  1  system clock; all logic on rising edge.
- arst  in  1  asynchronous active-high reset.
- div_wr  in  1  write strobe for a channel ratio.
- div_sel  in  SEL_W  channel index to write. SEL_W = max(1, clog2(NUM_CH)).
- div_data  in  DIV_W  new divide ratio N.
- sync  in  1  synchronous phase-align of all channels.
- tick  out  NUM_CH  per-channel one-cycle enable strobe, registered.
- clk_out  out  NUM_CH  per-channel divided square wave (see Optional Feature).

Behaviour:
- Per-channel state:
  - shadow[i] (DIV_W): last written ratio.
  - act[i] (DIV_W): ratio in use.
  - cnt[i] (DIV_W): phase counter.
  - tick[i]: registered strobe.
- Reset (arst high, async):
  - shadow[i] = act[i] = DIV_INIT slice.
  - cnt = 0, tick = 0, clk_out = 0.
  - Reset applies immediately at any time, including mid-period. No partial state survives.
- Counting, per channel each edge with act != 0:
  - If cnt == act-1: cnt <= 0, tick <= 1, and act <= shadow (reload point).
  - Else: cnt <= cnt+1, tick <= 0.
- Period: with ratio N >= 1, tick is high exactly 1 of every N cycles.
  - First tick after reset release is high in the cycle following the Nth rising edge.
  - N=1: tick is constantly high from the first edge on.
- Disabled channel (act == 0):
  - tick held 0, cnt held 0.
  - act <= shadow every edge, so a nonzero write takes effect on the edge after the write.
- Writes:
  - On div_wr, shadow[div_sel] <= div_data.
  - div_sel >= NUM_CH is ignored.
  - A running channel keeps its old ratio until its next reload. No glitched or truncated period.
  - Writing 0 to a running channel stops it after the current period completes.
- sync, all channels:
  - cnt <= 0, tick <= 0, act <= shadow; clk_out unchanged.
  - sync has priority over the count/reload rule.
  - sync and div_wr in the same cycle: the written value enters shadow and act together, so the new ratio is used from the sync edge.
- Arithmetic: unsigned; cnt never exceeds act-1. N = 2^DIV_W - 1 is the maximum period.
- Latency: div_wr/sync to effect is one edge. tick is registered with no combinational path from any input.

Optional Feature:
- Macro CLKDIV_PROG_TOGGLE_EN.
- Defined: clk_out[i] toggles on every edge where tick[i] is set to 1.
  - Gives a 50% duty wave at f_clk/(2N).
  - N=1 gives f_clk/2.
  - Held at its value while the channel is disabled or sync is active.
- Undefined: clk_out is tied to 0 and no toggle flops are instantiated. The port list is unchanged.

Test Plan:
- Defaults: release arst, run 64 cycles -> tick[0] high every cycle; tick[1] high on cycles 4,8,12..; tick[2] high on cycles 8,16,24.. (cycle 1 = first edge after release).
- Reprogram mid-period: at cycle 6 write ch1=3 -> tick[1] still at cycle 8, then at 11,14,17.
- Disable/enable: write ch2=0 at cycle 2 -> tick[2] at 8, then silent for 40 cycles. Write ch2=5 at cycle 50 -> ticks at cycles 56,61,66.
- Sync with write: free-run 13 cycles, then assert sync plus write ch0=2 in the same cycle -> all ticks 0 that cycle. Afterwards tick[0] every 2, tick[1] every 4, tick[2] every 8, all aligned to the sync edge.
- Async reset mid-operation: pulse arst between edges at cycle 37 -> tick/cnt/clk_out cleared immediately, ratios back to 1/4/8, and the sequence replays identically to the defaults test.
- With CLKDIV_PROG_TOGGLE_EN: ch1=4 -> clk_out[1] period 8 cycles, 4 high/4 low. Without the macro, clk_out stays 0 for the whole run.

Source files
------------

// File: rtl/clkdiv_prog.sv
// clkdiv_prog: NUM_CH programmable clock-enable tick generators with shadowed ratio reload and sync.
// Optional divided square-wave outputs on clk_out when CLKDIV_PROG_TOGGLE_EN is defined.
module clkdiv_prog #(
  parameter int                          NUM_CH   = 3,
  parameter int                          DIV_W    = 8,
  parameter logic [NUM_CH*DIV_W-1:0]     DIV_INIT = {8'd8, 8'd4, 8'd1},
  localparam int                         SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [DIV_W-1:0]  div_data,
  input  logic              sync,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  localparam logic [SEL_W:0] NUM_CH_L = (SEL_W+1)'(NUM_CH);

  logic w_sel_ok;
  assign w_sel_ok = ({1'b0, div_sel} < NUM_CH_L);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] r_shadow;
    logic [DIV_W-1:0] r_act;
    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;
    logic             w_wr_hit;
    logic [DIV_W-1:0] w_shadow_nxt;
    logic             w_act_zero;
    logic             w_at_end;

    assign w_wr_hit     = div_wr & w_sel_ok & (div_sel == SEL_W'(g));
    assign w_shadow_nxt = w_wr_hit ? div_data : r_shadow;
    assign w_act_zero   = (r_act == '0);
    assign w_at_end     = (r_cnt == (r_act - DIV_W'(1)));

    // sync reloads from the merged shadow so a same-cycle write is used from the sync edge
    always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
        r_shadow <= DIV_INIT[g*DIV_W +: DIV_W];
        r_act    <= DIV_INIT[g*DIV_W +: DIV_W];
        r_cnt    <= '0;
        r_tick   <= 1'b0;
      end else begin
        r_shadow <= w_shadow_nxt;
        if (sync) begin
          r_act  <= w_shadow_nxt;
          r_cnt  <= '0;
          r_tick <= 1'b0;
        end else if (w_act_zero) begin
          r_act  <= r_shadow;
          r_cnt  <= '0;
          r_tick <= 1'b0;
        end else if (w_at_end) begin
          r_act  <= r_shadow;
          r_cnt  <= '0;
          r_tick <= 1'b1;
        end else begin
          r_cnt  <= r_cnt + DIV_W'(1);
          r_tick <= 1'b0;
        end
      end
    end

    assign tick[g] = r_tick;

`ifdef CLKDIV_PROG_TOGGLE_EN
    logic r_clk_out;

    always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
        r_clk_out <= 1'b0;
      end else if (!sync && !w_act_zero && w_at_end) begin
        r_clk_out <= ~r_clk_out;
      end
    end

    assign clk_out[g] = r_clk_out;
`else
    assign clk_out[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed bench for clkdiv_prog: default ratios, reprogramming, disable, sync+write, async reset.
module tb_clkdiv_prog;

  logic       clk;
  logic       arst;
  logic       div_wr;
  logic [1:0] div_sel;
  logic [7:0] div_data;
  logic       sync;
  logic [2:0] tick;
  logic [2:0] clk_out;

  int cyc;
  int n_chk;
  int n_err;

  clkdiv_prog #(
    .NUM_CH  (3),
    .DIV_W   (8),
    .DIV_INIT({8'd8, 8'd4, 8'd1})
  ) dut (
    .clk     (clk),
    .arst    (arst),
    .div_wr  (div_wr),
    .div_sel (div_sel),
    .div_data(div_data),
    .sync    (sync),
    .tick    (tick),
    .clk_out (clk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    div_wr   = 1'b0;
    div_sel  = 2'd0;
    div_data = 8'd0;
    sync     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    arst = 1'b1;
    #2;
    chk("rst_tick", {29'd0, tick}, 32'd0);
    chk("rst_clk_out", {29'd0, clk_out}, 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    arst = 1'b0;
    cyc  = 0;
  endtask

  function automatic logic [2:0] dflt_tick(input int c);
    return {(c % 8) == 0, (c % 4) == 0, 1'b1};
  endfunction

  function automatic logic [2:0] dflt_co(input int c);
`ifdef CLKDIV_PROG_TOGGLE_EN
    return {((c / 8) % 2) == 1, ((c / 4) % 2) == 1, (c % 2) == 1};
`else
    return 3'b000;
`endif
  endfunction

  task automatic run_defaults(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      chk("dflt_tick", {29'd0, tick}, {29'd0, dflt_tick(cyc)});
      chk("dflt_clk_out", {29'd0, clk_out}, {29'd0, dflt_co(cyc)});
    end
  endtask

  initial begin
    logic [2:0] exp_t;
    logic [2:0] co_base;
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    arst  = 1'b1;
    idle_inputs();

    // defaults: ratios 1/4/8 from reset
    do_reset();
    run_defaults(64);

    // reprogram ch1 to 3 mid-period, plus an out-of-range select that must be ignored
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      if (c == 6) begin
        div_wr = 1'b1; div_sel = 2'd1; div_data = 8'd3;
      end else if (c == 9) begin
        div_wr = 1'b1; div_sel = 2'd3; div_data = 8'd1;
      end else begin
        idle_inputs();
      end
      step();
      exp_t[0] = 1'b1;
      exp_t[1] = (c == 4) || (c == 8) || (c > 8 && ((c - 8) % 3) == 0);
      exp_t[2] = (c % 8) == 0;
      chk("reprog_tick", {29'd0, tick}, {29'd0, exp_t});
    end
    idle_inputs();

    // disable ch2 after its current period, then re-enable with ratio 5
    do_reset();
    for (int c = 1; c <= 70; c++) begin
      if (c == 2) begin
        div_wr = 1'b1; div_sel = 2'd2; div_data = 8'd0;
      end else if (c == 50) begin
        div_wr = 1'b1; div_sel = 2'd2; div_data = 8'd5;
      end else begin
        idle_inputs();
      end
      step();
      exp_t[0] = 1'b1;
      exp_t[1] = (c % 4) == 0;
      exp_t[2] = (c == 8) || (c == 56) || (c == 61) || (c == 66);
      chk("disable_tick", {29'd0, tick}, {29'd0, exp_t});
    end
    idle_inputs();

    // sync together with a write of ch0=2 after 13 free-running cycles
    do_reset();
    run_defaults(13);
    co_base = dflt_co(13);
    sync = 1'b1; div_wr = 1'b1; div_sel = 2'd0; div_data = 8'd2;
    step();
    idle_inputs();
    chk("sync_tick", {29'd0, tick}, 32'd0);
    chk("sync_clk_out", {29'd0, clk_out}, {29'd0, co_base});
    for (int k = 1; k <= 24; k++) begin
      step();
      exp_t = {(k % 8) == 0, (k % 4) == 0, (k % 2) == 0};
      chk("post_sync_tick", {29'd0, tick}, {29'd0, exp_t});
`ifdef CLKDIV_PROG_TOGGLE_EN
      chk("post_sync_clk_out", {29'd0, clk_out},
          {29'd0, co_base ^ {((k / 8) % 2) == 1, ((k / 4) % 2) == 1, ((k / 2) % 2) == 1}});
`else
      chk("post_sync_clk_out", {29'd0, clk_out}, 32'd0);
`endif
    end

    // async reset pulsed between edges at cycle 37, then defaults replay
    do_reset();
    run_defaults(36);
    #3;
    arst = 1'b1;
    #1;
    chk("arst_mid_tick", {29'd0, tick}, 32'd0);
    chk("arst_mid_clk_out", {29'd0, clk_out}, 32'd0);
    #2;
    arst = 1'b0;
    cyc  = 0;
    run_defaults(64);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
